// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - ALU opcode, ALUOp and funct encodings shared by the ID/EX stage
package ex_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_BAD = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - combinational ALUOp/funct to 4-bit ALU opcode decode
module alu_ctrl
    import ex_pkg::*;
(
    input  logic [1:0] alu_op_sel,
    input  logic [5:0] funct,
    output logic [3:0] ctrl
);

    always_comb begin
        ctrl = ALU_BAD;
        case (alu_op_sel)
            ALUOP_ADD: ctrl = ALU_ADD;
            ALUOP_SUB: ctrl = ALU_SUB;
            ALUOP_OR:  ctrl = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: ctrl = ALU_ADD;
                    FUNCT_SUB: ctrl = ALU_SUB;
                    FUNCT_AND: ctrl = ALU_AND;
                    FUNCT_OR:  ctrl = ALU_OR;
                    FUNCT_SLT: ctrl = ALU_SLT;
                    FUNCT_NOR: ctrl = ALU_NOR;
                    default:   ctrl = ALU_BAD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use detect
// Define ID_EX_FORWARDING_EN to enable EX/MEM and MEM/WB operand forwarding.
module id_ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [1:0]        id_alu_op,
    input  logic [5:0]        id_funct,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exmem_reg_write,
    input  logic [4:0]        exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [4:0]        memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [4:0]        ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              load_hazard
);

    logic [3:0]        dec_op;
    logic [DATA_W-1:0] rs_q, rt_q, imm_q;
    logic [4:0]        ex_rs, ex_rt;
    logic              alu_src_q;
    logic [DATA_W-1:0] fwd_rs, fwd_rt;

    alu_ctrl u_alu_ctrl (
        .alu_op_sel (id_alu_op),
        .funct      (id_funct),
        .ctrl       (dec_op)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_dest       <= '0;
            alu_op        <= ALU_AND;
            rs_q          <= '0;
            rt_q          <= '0;
            imm_q         <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            alu_src_q     <= 1'b0;
        end else if (flush) begin
            // Bubble: only validity and side-effecting controls matter here
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
        end else if (!stall) begin
            ex_valid      <= in_valid;
            ex_reg_write  <= id_reg_write & in_valid;
            ex_mem_read   <= id_mem_read & in_valid;
            ex_mem_write  <= id_mem_write & in_valid;
            ex_mem_to_reg <= id_mem_to_reg & in_valid;
            ex_dest       <= id_reg_dst ? id_rd : id_rt;
            alu_op        <= dec_op;
            rs_q          <= id_rs_data;
            rt_q          <= id_rt_data;
            imm_q         <= id_imm;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            alu_src_q     <= id_alu_src;
        end
    end

`ifdef ID_EX_FORWARDING_EN
    // MEM/WB applied first so a matching EX/MEM (younger result) overrides it
    always_comb begin
        fwd_rs = rs_q;
        if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_rs)) fwd_rs = memwb_result;
        if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_rs)) fwd_rs = exmem_result;
    end

    always_comb begin
        fwd_rt = rt_q;
        if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_rt)) fwd_rt = memwb_result;
        if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_rt)) fwd_rt = exmem_result;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                          memwb_reg_write, memwb_rd, memwb_result, ex_rs, ex_rt};
    assign fwd_rs = rs_q;
    assign fwd_rt = rt_q;
`endif

    assign alu_a      = fwd_rs;
    assign alu_b      = alu_src_q ? imm_q : fwd_rt;
    assign ex_rt_data = fwd_rt;

    assign load_hazard = ex_valid & ex_mem_read & (ex_dest != 5'd0) &
                         ((ex_dest == id_rs) | (ex_dest == id_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage against a slot-level reference model
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_a, alu_b, ex_rt_data;
    logic [3:0]  alu_op;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_hazard;
    logic [4:0]  ex_dest;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_funct(id_funct), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_valid(ex_valid),
        .ex_rt_data(ex_rt_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .load_hazard(load_hazard)
    );

    typedef struct {
        logic        valid, rw, mr, mw, m2r, hz, known;
        logic [4:0]  dest;
        logic [3:0]  op;
        logic [31:0] a, b, rtd;
    } exp_t;

    typedef struct {
        logic        valid, rw, mr, mw, m2r, src, known;
        logic [4:0]  dest, rs, rt;
        logic [3:0]  op;
        logic [31:0] rs_data, rt_data, imm;
    } slot_t;

    exp_t   q[$];
    slot_t  slot;
    int     n_cmp = 0;
    int     n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] ref_op(input logic [1:0] aop, input logic [5:0] f);
        if (aop == 2'b00) return 4'b0010;
        if (aop == 2'b01) return 4'b0110;
        if (aop == 2'b11) return 4'b0001;
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b100111: return 4'b1100;
            default:   return 4'b1111;
        endcase
    endfunction

    // Operand value the EX stage should see for source register num
    function automatic logic [31:0] ref_fwd(input logic [4:0] num, input logic [31:0] regval);
`ifdef ID_EX_FORWARDING_EN
        if (num != 0 && exmem_reg_write && exmem_rd == num) return exmem_result;
        if (num != 0 && memwb_reg_write && memwb_rd == num) return memwb_result;
`endif
        return regval;
    endfunction

    // Advance the model across one rising edge, queue the expected outputs, move to next negedge
    task automatic tick();
        exp_t e;
        if (rst) begin
            slot = '{default: '0};
            slot.known = 1'b1;
        end else if (flush) begin
            {slot.valid, slot.rw, slot.mr, slot.mw, slot.m2r, slot.known} = '0;
        end else if (!stall) begin
            slot.valid = in_valid;
            slot.rw = id_reg_write && in_valid;
            slot.mr = id_mem_read && in_valid;
            slot.mw = id_mem_write && in_valid;
            slot.m2r = id_mem_to_reg && in_valid;
            slot.dest = id_reg_dst ? id_rd : id_rt;
            slot.op = ref_op(id_alu_op, id_funct);
            slot.rs = id_rs; slot.rt = id_rt;
            slot.rs_data = id_rs_data; slot.rt_data = id_rt_data; slot.imm = id_imm;
            slot.src = id_alu_src;
            slot.known = 1'b1;
        end
        e.valid = slot.valid; e.rw = slot.rw; e.mr = slot.mr; e.mw = slot.mw; e.m2r = slot.m2r;
        e.known = slot.known; e.dest = slot.dest; e.op = slot.op;
        e.a = ref_fwd(slot.rs, slot.rs_data);
        e.rtd = ref_fwd(slot.rt, slot.rt_data);
        e.b = slot.src ? slot.imm : e.rtd;
        e.hz = slot.valid && slot.mr && slot.dest != 0 && (slot.dest == id_rs || slot.dest == id_rt);
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ex_valid", ex_valid, e.valid);
                chk("ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
                    {e.rw, e.mr, e.mw, e.m2r});
                chk("load_hazard", load_hazard, e.hz);
                if (e.known) begin
                    chk("ex_dest", ex_dest, e.dest);
                    chk("alu_op", alu_op, e.op);
                    chk("alu_a", alu_a, e.a);
                    chk("alu_b", alu_b, e.b);
                    chk("ex_rt_data", ex_rt_data, e.rtd);
                end
            end
        end
    end

    task automatic clear_in();
        {in_valid, stall, flush, id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
         id_mem_write, id_mem_to_reg, exmem_reg_write, memwb_reg_write} = '0;
        {id_rs_data, id_rt_data, id_imm, exmem_result, memwb_result} = '0;
        {id_rs, id_rt, id_rd, exmem_rd, memwb_rd} = '0;
        id_alu_op = 2'b00; id_funct = 6'b0;
    endtask

    task automatic rand_in();
        logic [5:0] functs [8];
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000000, 6'b111111};
        in_valid = ($urandom_range(0, 9) != 0);
        stall = ($urandom_range(0, 5) == 0);
        flush = ($urandom_range(0, 7) == 0);
        rst = ($urandom_range(0, 60) == 0);
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
        id_alu_op = 2'($urandom_range(0, 3)); id_funct = functs[$urandom_range(0, 7)];
        id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
        id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
        id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
        exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
        memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
    endtask

    initial begin : stim
        int waited;
        clear_in();
        rst = 1'b1;
        slot = '{default: '0};
        @(negedge clk);
        tick();
        rst = 1'b0;

        // R-type subtract
        in_valid = 1'b1; id_alu_op = 2'b10; id_funct = 6'b100010;
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_reg_dst = 1'b1; id_reg_write = 1'b1;
        id_rs_data = 32'd5; id_rt_data = 32'd3;
        tick();
        chk("rtype_op", alu_op, 4'b0110);
        chk("rtype_a", alu_a, 32'd5);
        chk("rtype_b", alu_b, 32'd3);

        // Both forwarding sources match rs=8
        id_rs = 5'd8; id_rs_data = 32'h77;
        exmem_reg_write = 1'b1; exmem_rd = 5'd8; exmem_result = 32'h11;
        memwb_reg_write = 1'b1; memwb_rd = 5'd8; memwb_result = 32'h22;
        tick();
`ifdef ID_EX_FORWARDING_EN
        chk("fwd_both", alu_a, 32'h11);
`else
        chk("fwd_both", alu_a, 32'h77);
`endif
        stall = 1'b1; exmem_rd = 5'd0;
        tick();
`ifdef ID_EX_FORWARDING_EN
        chk("fwd_memwb", alu_a, 32'h22);
`else
        chk("fwd_memwb", alu_a, 32'h77);
`endif
        stall = 1'b0;

        // Register 0 is never forwarded
        id_rs = 5'd0; id_rs_data = 32'h55; exmem_rd = 5'd0; memwb_rd = 5'd0;
        tick();
        chk("reg0_a", alu_a, 32'h55);

        // Load-use: lw $9 in EX, next instruction reads $9
        clear_in();
        in_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_mem_to_reg = 1'b1;
        id_rt = 5'd9; id_reg_dst = 1'b0;
        tick();
        id_mem_read = 1'b0; id_mem_to_reg = 1'b0; id_rs = 5'd1; id_rt = 5'd9; stall = 1'b1;
        tick();
        chk("lu_hazard", load_hazard, 1'b1);
        chk("lu_hold_dest", ex_dest, 5'd9);
        stall = 1'b0; flush = 1'b1;
        tick();
        chk("lu_flush_valid", ex_valid, 1'b0);
        flush = 1'b0;

        // Immediate operand
        clear_in();
        in_valid = 1'b1; id_alu_op = 2'b00; id_alu_src = 1'b1; id_imm = 32'hFFFF_FFFC; id_rt_data = 32'h9;
        tick();
        chk("imm_op", alu_op, 4'b0010);
        chk("imm_b", alu_b, 32'hFFFF_FFFC);

        // Asynchronous reset while stalling and flushing
        stall = 1'b1; flush = 1'b1; id_rs_data = 32'hABCD;
        rst = 1'b1;
        #1;
        chk("async_valid", ex_valid, 1'b0);
        chk("async_op", alu_op, 4'b0000);
        chk("async_a", alu_a, 32'h0);
        tick();
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        tick();

        for (int i = 0; i < 400; i++) begin
            rand_in();
            tick();
        end
        rst = 1'b0; stall = 1'b1; flush = 1'b0;

        waited = 0;
        while (q.size() != 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width.
REQ-002 SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: rst  in  1  asynchronous active-high reset.
REQ-005 Ports: in_valid in 1 ID slot holds an instruction; stall in 1 hold register; flush in 1 load bubble.
REQ-006 Ports: id_rs_data, id_rt_data, id_imm  in  DATA_W  register-file reads, sign-extended immediate.
REQ-007 Ports: id_rs, id_rt, id_rd  in  5  register numbers.
REQ-008 Ports: id_alu_op in 2, id_funct in 6, id_alu_src in 1, id_reg_dst in 1.
REQ-009 Ports: id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits.
REQ-010 Ports: exmem_reg_write in 1, exmem_rd in 5, exmem_result in DATA_W: EX/MEM forwarding source.
REQ-011 Ports: memwb_reg_write in 1, memwb_rd in 5, memwb_result in DATA_W: MEM/WB forwarding source.
REQ-012 Ports: alu_a, alu_b out DATA_W; alu_op out 4; ALU operands and 4-bit ALU opcode.
REQ-013 Ports: ex_valid out 1, ex_rt_data out DATA_W (store data), ex_dest out 5.
REQ-014 Ports: ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out 1; load_hazard out 1.

Function
REQ-015 Capture priority on each rising clk SHALL be: rst > flush > stall > load.
REQ-016 Flush SHALL clear ex_valid and all four control outputs; data fields are don't-care.
REQ-017 Stall without flush SHALL hold every register unchanged.
REQ-018 Load SHALL capture all ID inputs; ex_valid <= in_valid; controls AND-ed with in_valid.
REQ-019 ex_dest SHALL be id_rd when id_reg_dst=1, else id_rt, captured at load.
REQ-020 alu_op SHALL be decoded at load and registered: ALUOp 00->0010, 01->0110, 11->0001, 10->funct decode.
REQ-021 Funct decode: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100, other->1111.
REQ-022 Forwarded rs: exmem_result if exmem_reg_write, exmem_rd!=0, exmem_rd==rs; else memwb_result under same test; else registered rs data.
REQ-023 Forwarded rt SHALL use the identical rule; EX/MEM SHALL win over MEM/WB when both match.
REQ-024 Register 0 SHALL never be forwarded.
REQ-025 alu_a = forwarded rs; alu_b = imm when alu_src, else forwarded rt; ex_rt_data = forwarded rt; all combinational.
REQ-026 load_hazard SHALL be ex_valid & ex_mem_read & ex_dest!=0 & (ex_dest==id_rs | ex_dest==id_rt), combinational.
REQ-027 Latency: ID inputs SHALL appear on outputs one cycle after load.

Reset
REQ-028 rst SHALL asynchronously clear every register: ex_valid=0, controls=0, ex_dest=0, alu_op=0000, data=0.
REQ-029 rst asserted mid-stall or mid-flush SHALL override both; first load after deassertion SHALL proceed normally.

Configuration
REQ-030 Macro ID_EX_FORWARDING_EN defined: forwarding per REQ-022..024.
REQ-031 Macro undefined: forwarded rs/rt SHALL equal registered register-file values; forwarding inputs unused; load_hazard unchanged.

Structure
REQ-032 Shared package ex_pkg SHALL hold the 4-bit ALU opcodes, 2-bit ALUOp encodings and funct constants.
REQ-033 Funct/ALUOp decode SHALL be sub-module alu_ctrl (combinational); forwarding mux stays inline.

Verification
REQ-034 Reset: rst=1 mid-run -> ex_valid=0, alu_op=0000, alu_a=0 immediately.
REQ-035 R-type sub: ALUOp=10, funct=100010, rs=5, rt=3 -> next cycle alu_op=0110, alu_a=5, alu_b=3.
REQ-036 Double forward: rs=8, exmem_rd=8 result 0x11, memwb_rd=8 result 0x22 -> alu_a=0x11; exmem_rd=0 -> 0x22.
REQ-037 Register 0: rs=0, exmem_rd=0, exmem_reg_write=1 -> alu_a=registered rs data.
REQ-038 Load-use: lw to $9 in EX, ID rt=9 -> load_hazard=1; stall=1 holds outputs; flush=1 -> ex_valid=0.
REQ-039 Immediate: ALUOp=00, alu_src=1, imm=0xFFFFFFFC -> alu_op=0010, alu_b=0xFFFFFFFC.
